urt_rx_fsm: RTL and testbench

- Receive-side sequencer for the UART RX path.
- Detects the start bit and owns the oversampling edge counter and the bit counter.
- Drives the enables for the data sampler, deserializer, start/parity/stop checkers; the deserializer shifts when deser_en is high and edge_cnt equals Prescale-1.
- Qualifies the assembled byte with a one-cycle data_valid pulse, or reports a frame error.

---
 rtl/urt_rx_fsm_if.sv | 59 +++++
 rtl/urt_rx_fsm.sv | 171 +++++++++++++++++
 tb/tb_urt_rx_fsm.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/urt_rx_fsm_if.sv
// Signal bundle between the UART RX sequencer and its sampler/checker/deserializer neighbours.
// The master side is the sequencer; the slave side is the surrounding receive datapath.
`timescale 1ns/1ps

interface urt_rx_fsm_if #(
    parameter int unsigned PRESCALE_WIDTH = 5
);
    logic                      RX_IN_FSM_RX;
    logic                      PAR_EN_FSM_RX;
    logic [PRESCALE_WIDTH-1:0] Prescale_FSM_RX;
    logic                      par_err_FSM_RX;
    logic                      strt_glitch_FSM_RX;
    logic                      stp_err_FSM_RX;
    logic [3:0]                edge_cnt_FSM_RX;
    logic [3:0]                bit_cnt_FSM_RX;
    logic                      dat_samp_en_FSM_RX;
    logic                      deser_en_FSM_RX;
    logic                      strt_chk_en_FSM_RX;
    logic                      par_chk_en_FSM_RX;
    logic                      stp_chk_en_FSM_RX;
    logic                      data_valid_FSM_RX;
    logic                      frame_err_FSM_RX;

    modport master (
        input  RX_IN_FSM_RX,
        input  PAR_EN_FSM_RX,
        input  Prescale_FSM_RX,
        input  par_err_FSM_RX,
        input  strt_glitch_FSM_RX,
        input  stp_err_FSM_RX,
        output edge_cnt_FSM_RX,
        output bit_cnt_FSM_RX,
        output dat_samp_en_FSM_RX,
        output deser_en_FSM_RX,
        output strt_chk_en_FSM_RX,
        output par_chk_en_FSM_RX,
        output stp_chk_en_FSM_RX,
        output data_valid_FSM_RX,
        output frame_err_FSM_RX
    );

    modport slave (
        output RX_IN_FSM_RX,
        output PAR_EN_FSM_RX,
        output Prescale_FSM_RX,
        output par_err_FSM_RX,
        output strt_glitch_FSM_RX,
        output stp_err_FSM_RX,
        input  edge_cnt_FSM_RX,
        input  bit_cnt_FSM_RX,
        input  dat_samp_en_FSM_RX,
        input  deser_en_FSM_RX,
        input  strt_chk_en_FSM_RX,
        input  par_chk_en_FSM_RX,
        input  stp_chk_en_FSM_RX,
        input  data_valid_FSM_RX,
        input  frame_err_FSM_RX
    );
endinterface

// File: rtl/urt_rx_fsm.sv
// UART RX sequencer: start detection, oversampling edge/bit counters, checker enables and
// byte qualification (data_valid) or frame_err reporting.
`timescale 1ns/1ps

module urt_rx_fsm #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 5
) (
    input logic             CLK_FSM_RX,
    input logic             RST_FSM_RX,
    urt_rx_fsm_if.master    bus
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    localparam logic [3:0]                LastBit  = 4'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] Presc8   = PRESCALE_WIDTH'(8);
    localparam logic [PRESCALE_WIDTH-1:0] Presc16  = PRESCALE_WIDTH'(16);
    localparam logic [PRESCALE_WIDTH-1:0] PrescOne = PRESCALE_WIDTH'(1);

    state_e                    state_q, state_d;
    logic [3:0]                edge_cnt_q, edge_cnt_d;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      par_en_q, par_en_d;
    logic                      par_flag_q, par_flag_d;
    logic                      data_valid_q, data_valid_d;
    logic                      frame_err_q, frame_err_d;
    // A frame may only begin once the line has been seen high since reset.
    logic                      line_armed_q, line_armed_d;

    logic bit_end;
    logic presc_legal;

    assign bit_end      = (PRESCALE_WIDTH'(edge_cnt_q) == (presc_q - PrescOne));
    assign presc_legal  = (bus.Prescale_FSM_RX == Presc8) || (bus.Prescale_FSM_RX == Presc16);
    assign line_armed_d = line_armed_q | bus.RX_IN_FSM_RX;

    always_ff @(posedge CLK_FSM_RX or negedge RST_FSM_RX) begin
        if (!RST_FSM_RX) begin
            state_q      <= StIdle;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            presc_q      <= '0;
            par_en_q     <= 1'b0;
            par_flag_q   <= 1'b0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            line_armed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            presc_q      <= presc_d;
            par_en_q     <= par_en_d;
            par_flag_q   <= par_flag_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            line_armed_q <= line_armed_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        presc_d      = presc_q;
        par_en_d     = par_en_q;
        par_flag_d   = par_flag_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q != StIdle) begin
            edge_cnt_d = bit_end ? 4'd0 : edge_cnt_q + 4'd1;
        end

        unique case (state_q)
            StIdle: begin
                edge_cnt_d = '0;
                if (!bus.RX_IN_FSM_RX && line_armed_q && presc_legal) begin
                    presc_d    = bus.Prescale_FSM_RX;
                    par_en_d   = bus.PAR_EN_FSM_RX;
                    par_flag_d = 1'b0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    if (bus.strt_glitch_FSM_RX) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_cnt_q == LastBit) begin
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    par_flag_d = bus.par_err_FSM_RX;
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    if (!bus.stp_err_FSM_RX && !par_flag_q) begin
                        data_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    // Enables are a pure decode of the state register.
    always_comb begin
        bus.dat_samp_en_FSM_RX = 1'b0;
        bus.deser_en_FSM_RX    = 1'b0;
        bus.strt_chk_en_FSM_RX = 1'b0;
        bus.par_chk_en_FSM_RX  = 1'b0;
        bus.stp_chk_en_FSM_RX  = 1'b0;
        unique case (state_q)
            StIdle: ;
            StStart: begin
                bus.strt_chk_en_FSM_RX = 1'b1;
                bus.dat_samp_en_FSM_RX = 1'b1;
            end
            StData: begin
                bus.deser_en_FSM_RX    = 1'b1;
                bus.dat_samp_en_FSM_RX = 1'b1;
            end
            StParity: begin
                bus.par_chk_en_FSM_RX  = 1'b1;
                bus.dat_samp_en_FSM_RX = 1'b1;
            end
            StStop: begin
                bus.stp_chk_en_FSM_RX  = 1'b1;
                bus.dat_samp_en_FSM_RX = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.edge_cnt_FSM_RX   = edge_cnt_q;
    assign bus.bit_cnt_FSM_RX    = bit_cnt_q;
    assign bus.data_valid_FSM_RX = data_valid_q;
    assign bus.frame_err_FSM_RX  = frame_err_q;

endmodule

// File: tb/tb_urt_rx_fsm.sv
// Directed bench for urt_rx_fsm: frames are tracked cycle by cycle against a position-based
// model (cycle index within the frame -> expected counters, enables and pulses).
`timescale 1ns/1ps

module tb_urt_rx_fsm;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    urt_rx_fsm_if #(.PRESCALE_WIDTH(PW)) bus ();

    urt_rx_fsm #(
        .DATA_WIDTH    (DW),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .CLK_FSM_RX(clk),
        .RST_FSM_RX(rst_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int dv_stamp[$];

    always @(posedge clk) cyc <= cyc + 1;

    logic [14:0] outs_w;
    assign outs_w = {bus.edge_cnt_FSM_RX, bus.bit_cnt_FSM_RX, bus.dat_samp_en_FSM_RX,
                     bus.deser_en_FSM_RX, bus.strt_chk_en_FSM_RX, bus.par_chk_en_FSM_RX,
                     bus.stp_chk_en_FSM_RX, bus.data_valid_FSM_RX, bus.frame_err_FSM_RX};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle c = 0 is the first START cycle. Checker inputs carry noise (1) everywhere except
    // at their own bit end, where they carry the requested verdict.
    task automatic run_frame(input string tag, input int p, input bit par, input bit glitch,
                             input bit perr, input bit serr, input logic [7:0] data,
                             input bit b2b, input bit chg);
        int total, c_last;
        int e_edge, e_bit, e_en, e_pulse, n_deser, n_par, n_dv, n_fe;
        bit dv_exp;
        total  = p * (DW + 2 + (par ? 1 : 0));
        c_last = glitch ? p + 3 : (b2b ? total : total + 3);
        dv_exp = !glitch && !perr && !serr;
        e_edge = 0; e_bit = 0; e_en = 0; e_pulse = 0;
        n_deser = 0; n_par = 0; n_dv = 0; n_fe = 0;
        bus.RX_IN_FSM_RX = 1'b0;
        for (int c = 0; c <= c_last; c++) begin
            int ph;
            bit idle_e;
            bit noise;
            logic [3:0] edge_x, bit_x;
            logic [4:0] en_x, en_a;
            logic [1:0] pl_x, pl_a;
            @(negedge clk);
            ph     = c / p;
            idle_e = glitch ? (c >= p) : (c >= total);
            edge_x = idle_e ? 4'd0 : 4'(c % p);
            if (idle_e || ph == 0)  bit_x = 4'd0;
            else if (ph <= DW)      bit_x = 4'(ph - 1);
            else                    bit_x = 4'(DW - 1);
            // {samp, deser, strt, par, stp}
            if (idle_e)                       en_x = 5'b00000;
            else if (ph == 0)                 en_x = 5'b10100;
            else if (ph <= DW)                en_x = 5'b11000;
            else if (par && ph == DW + 1)     en_x = 5'b10010;
            else                              en_x = 5'b10001;
            pl_x = (!glitch && c == total) ? (dv_exp ? 2'b10 : 2'b01) : 2'b00;
            en_a = {bus.dat_samp_en_FSM_RX, bus.deser_en_FSM_RX, bus.strt_chk_en_FSM_RX,
                    bus.par_chk_en_FSM_RX, bus.stp_chk_en_FSM_RX};
            pl_a = {bus.data_valid_FSM_RX, bus.frame_err_FSM_RX};
            if (bus.edge_cnt_FSM_RX !== edge_x) e_edge++;
            if (bus.bit_cnt_FSM_RX !== bit_x)   e_bit++;
            if (en_a !== en_x)                  e_en++;
            if (pl_a !== pl_x)                  e_pulse++;
            if (bus.deser_en_FSM_RX === 1'b1)   n_deser++;
            if (bus.par_chk_en_FSM_RX === 1'b1) n_par++;
            if (bus.data_valid_FSM_RX === 1'b1) begin
                n_dv++;
                dv_stamp.push_back(cyc);
            end
            if (bus.frame_err_FSM_RX === 1'b1)  n_fe++;
            noise = !idle_e;
            if (idle_e)                   bus.RX_IN_FSM_RX = (b2b && c == total) ? 1'b0 : 1'b1;
            else if (ph == 0)             bus.RX_IN_FSM_RX = 1'b0;
            else if (ph <= DW)            bus.RX_IN_FSM_RX = data[ph-1];
            else if (par && ph == DW + 1) bus.RX_IN_FSM_RX = ^data;
            else                          bus.RX_IN_FSM_RX = 1'b1;
            bus.strt_glitch_FSM_RX = (c == p - 1) ? glitch : noise;
            bus.par_err_FSM_RX     = (par && c == p * (DW + 2) - 1) ? perr : noise;
            bus.stp_err_FSM_RX     = (c == total - 1) ? serr : noise;
            if (chg && c == 3) begin
                bus.Prescale_FSM_RX = 5'd16;
                bus.PAR_EN_FSM_RX   = 1'b1;
            end
        end
        bus.strt_glitch_FSM_RX = 1'b0;
        bus.par_err_FSM_RX     = 1'b0;
        bus.stp_err_FSM_RX     = 1'b0;
        if (!b2b) bus.RX_IN_FSM_RX = 1'b1;
        check({tag, "_edge_seq"}, e_edge, 0);
        check({tag, "_bit_seq"}, e_bit, 0);
        check({tag, "_enables"}, e_en, 0);
        check({tag, "_pulse_timing"}, e_pulse, 0);
        check({tag, "_deser_cycles"}, n_deser, glitch ? 0 : DW * p);
        check({tag, "_par_cycles"}, n_par, (par && !glitch) ? p : 0);
        check({tag, "_dv_count"}, n_dv, dv_exp ? 1 : 0);
        check({tag, "_fe_count"}, n_fe, (!glitch && !dv_exp) ? 1 : 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        bus.RX_IN_FSM_RX       = 1'b1;
        bus.PAR_EN_FSM_RX      = 1'b0;
        bus.Prescale_FSM_RX    = 5'd8;
        bus.par_err_FSM_RX     = 1'b0;
        bus.strt_glitch_FSM_RX = 1'b0;
        bus.stp_err_FSM_RX     = 1'b0;

        @(negedge clk);
        check("reset_outputs", outs_w, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outputs", outs_w, 0);

        run_frame("p8_a5", 8, 0, 0, 0, 0, 8'hA5, 0, 0);
        bus.Prescale_FSM_RX = 5'd16; bus.PAR_EN_FSM_RX = 1'b1;
        run_frame("p16_perr", 16, 1, 0, 1, 0, 8'h3C, 0, 0);
        bus.Prescale_FSM_RX = 5'd8; bus.PAR_EN_FSM_RX = 1'b0;
        run_frame("p8_glitch", 8, 0, 1, 0, 0, 8'h00, 0, 0);
        run_frame("p8_after_glitch", 8, 0, 0, 0, 0, 8'h5A, 0, 0);
        run_frame("p8_stop_err", 8, 0, 0, 0, 1, 8'hFF, 0, 0);
        bus.Prescale_FSM_RX = 5'd16; bus.PAR_EN_FSM_RX = 1'b1;
        run_frame("p16_par_ok", 16, 1, 0, 0, 0, 8'h81, 0, 0);
        bus.Prescale_FSM_RX = 5'd8; bus.PAR_EN_FSM_RX = 1'b0;

        dv_stamp.delete();
        run_frame("b2b_first", 8, 0, 0, 0, 0, 8'h12, 1, 0);
        run_frame("b2b_second", 8, 0, 0, 0, 0, 8'h34, 0, 0);
        check("b2b_dv_count", dv_stamp.size(), 2);
        if (dv_stamp.size() == 2) check("b2b_dv_gap", dv_stamp[1] - dv_stamp[0], 81);

        // Illegal prescale with the line held low must never leave IDLE.
        @(negedge clk);
        bus.Prescale_FSM_RX = 5'd12;
        bus.RX_IN_FSM_RX    = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (outs_w !== 15'd0) bad++;
        end
        check("illegal_prescale_idle", bad, 0);
        bus.RX_IN_FSM_RX = 1'b1;
        @(negedge clk);
        bus.Prescale_FSM_RX = 5'd8;

        run_frame("cfg_change_midframe", 8, 0, 0, 0, 0, 8'hC3, 0, 1);
        bus.Prescale_FSM_RX = 5'd8; bus.PAR_EN_FSM_RX = 1'b0;

        // Asynchronous reset during DATA at bit_cnt = 3 (cycle 34 = 8*(1+3)+2).
        @(negedge clk);
        bus.RX_IN_FSM_RX = 1'b0;
        for (int c = 0; c <= 34; c++) begin
            @(negedge clk);
            bus.RX_IN_FSM_RX = (c < 8) ? 1'b0 : 1'b1;
        end
        check("pre_reset_bit_cnt", bus.bit_cnt_FSM_RX, 3);
        check("pre_reset_edge_cnt", bus.edge_cnt_FSM_RX, 2);
        check("pre_reset_deser_en", bus.deser_en_FSM_RX, 1);
        #2 rst_n = 1'b0;
        bus.RX_IN_FSM_RX = 1'b0;
        #1 check("async_reset_outputs", outs_w, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (outs_w !== 15'd0) bad++;
        end
        check("post_reset_needs_fresh_low", bad, 0);
        bus.RX_IN_FSM_RX = 1'b1;
        @(negedge clk);
        run_frame("post_reset_frame", 8, 0, 0, 0, 0, 8'h69, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
